sync_arith_unit_mc: RTL

- Multi-cycle successor to the single-cycle synchronous arithmetic unit.
- Width is parametrised. Operation set is extended to iterative unsigned multiply and divide.
- Operands are accepted and results returned through valid/ready handshakes, so the unit can sit between an operand queue and a result sink in the datapath.
- Add/sub complete in one cycle. Mul/div use a shift-add / restoring-division engine lasting BITS cycles.

---
 rtl/sync_arith_unit_mc.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/sync_arith_unit_mc.sv
// Multi-cycle unsigned arithmetic unit: single-cycle add/sub plus iterative
// shift-add multiply and restoring divide, valid/ready handshake on both sides.
module sync_arith_unit_mc #(
  parameter int BITS = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [1:0]      i_op,
  input  logic [BITS-1:0] i_arg_A,
  input  logic [BITS-1:0] i_arg_B,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [BITS-1:0] o_result,
  output logic [BITS-1:0] o_remainder,
  output logic [3:0]      o_status
);

  localparam int CNT_W = $clog2(BITS + 1);

  localparam logic [1:0]       OP_ADD   = 2'b00;
  localparam logic [1:0]       OP_SUB   = 2'b01;
  localparam logic [1:0]       OP_MUL   = 2'b10;
  localparam logic [1:0]       OP_DIV   = 2'b11;
  localparam logic [BITS-1:0]  ZERO     = {BITS{1'b0}};
  localparam logic [BITS-1:0]  ONES     = {BITS{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(BITS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t            state_r, state_s;
  logic [1:0]        op_r, op_s;
  logic [BITS-1:0]   a_r, a_s;
  logic [BITS-1:0]   b_r, b_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [2*BITS-1:0] work_r, work_s;
  logic              ready_r, ready_s;
  logic              valid_r, valid_s;
  logic [BITS-1:0]   result_r, result_s;
  logic [BITS-1:0]   remainder_r, remainder_s;
  logic [3:0]        status_r, status_s;

  logic [BITS:0]     add_s, sub_s, mul_sum_s, div_shift_s, div_diff_s;
  logic [2*BITS-1:0] mul_next_s, div_next_s, step_s;

  function automatic logic [3:0] make_status(input logic [BITS-1:0] res,
                                             input logic err,
                                             input logic carry);
    return {err, res[BITS-1], (res == ZERO), carry};
  endfunction

  // Single-cycle sums and one iteration of the multiply/divide engines.
  // work_r holds {high, low} of the product, or {remainder, quotient/dividend}.
  always_comb begin
    add_s       = {1'b0, i_arg_A} + {1'b0, i_arg_B};
    sub_s       = {1'b0, i_arg_A} - {1'b0, i_arg_B};
    mul_sum_s   = {1'b0, work_r[2*BITS-1:BITS]} + (work_r[0] ? {1'b0, b_r} : {(BITS+1){1'b0}});
    mul_next_s  = {mul_sum_s, work_r[BITS-1:1]};
    div_shift_s = {work_r[2*BITS-1:BITS], work_r[BITS-1]};
    div_diff_s  = div_shift_s - {1'b0, b_r};
    if (div_diff_s[BITS]) begin
      div_next_s = {div_shift_s[BITS-1:0], work_r[BITS-2:0], 1'b0};
    end else begin
      div_next_s = {div_diff_s[BITS-1:0], work_r[BITS-2:0], 1'b1};
    end
    if (op_r == OP_MUL) begin
      step_s = mul_next_s;
    end else begin
      step_s = div_next_s;
    end
  end

  // Next-state and next-output logic of the IDLE/CALC/DONE controller
  always_comb begin
    state_s     = state_r;
    op_s        = op_r;
    a_s         = a_r;
    b_s         = b_r;
    cnt_s       = cnt_r;
    work_s      = work_r;
    ready_s     = ready_r;
    valid_s     = valid_r;
    result_s    = result_r;
    remainder_s = remainder_r;
    status_s    = status_r;
    case (state_r)
      ST_IDLE: begin
        ready_s = 1'b1;
        valid_s = 1'b0;
        if (i_valid && ready_r) begin
          op_s    = i_op;
          a_s     = i_arg_A;
          b_s     = i_arg_B;
          work_s  = {ZERO, i_arg_A};
          ready_s = 1'b0;
          case (i_op)
            OP_ADD: begin
              state_s     = ST_DONE;
              valid_s     = 1'b1;
              result_s    = add_s[BITS-1:0];
              remainder_s = ZERO;
              status_s    = make_status(add_s[BITS-1:0], 1'b0, add_s[BITS]);
            end
            OP_SUB: begin
              state_s     = ST_DONE;
              valid_s     = 1'b1;
              result_s    = sub_s[BITS-1:0];
              remainder_s = ZERO;
              status_s    = make_status(sub_s[BITS-1:0], 1'b0, sub_s[BITS]);
            end
            OP_MUL, OP_DIV: begin
              state_s = ST_CALC;
              cnt_s   = CNT_INIT;
            end
            default: begin
              state_s = ST_IDLE;
              ready_s = 1'b1;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        ready_s = 1'b0;
        cnt_s   = cnt_r - CNT_ONE;
        work_s  = step_s;
        if (cnt_r == CNT_ONE) begin
          state_s = ST_DONE;
          valid_s = 1'b1;
          if (op_r == OP_MUL) begin
            result_s    = step_s[BITS-1:0];
            remainder_s = ZERO;
            status_s    = make_status(step_s[BITS-1:0], 1'b0, |step_s[2*BITS-1:BITS]);
          end else if (b_r == ZERO) begin
            // Divide by zero still burns the full iteration count for fixed latency
            result_s    = ONES;
            remainder_s = a_r;
            status_s    = make_status(ONES, 1'b1, 1'b0);
          end else begin
            result_s    = step_s[BITS-1:0];
            remainder_s = step_s[2*BITS-1:BITS];
            status_s    = make_status(step_s[BITS-1:0], 1'b0, 1'b0);
          end
        end else begin
          state_s = ST_CALC;
        end
      end
      ST_DONE: begin
        ready_s = 1'b0;
        valid_s = 1'b1;
        if (i_ready) begin
          state_s = ST_IDLE;
          valid_s = 1'b0;
          ready_s = 1'b1;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ready_s = 1'b1;
        valid_s = 1'b0;
      end
    endcase
  end

  // State, latched operands and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r     <= ST_IDLE;
      op_r        <= 2'b00;
      a_r         <= ZERO;
      b_r         <= ZERO;
      cnt_r       <= CNT_ZERO;
      work_r      <= {ZERO, ZERO};
      ready_r     <= 1'b1;
      valid_r     <= 1'b0;
      result_r    <= ZERO;
      remainder_r <= ZERO;
      status_r    <= 4'b0000;
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      a_r         <= a_s;
      b_r         <= b_s;
      cnt_r       <= cnt_s;
      work_r      <= work_s;
      ready_r     <= ready_s;
      valid_r     <= valid_s;
      result_r    <= result_s;
      remainder_r <= remainder_s;
      status_r    <= status_s;
    end
  end

  assign o_ready     = ready_r;
  assign o_valid     = valid_r;
  assign o_result    = result_r;
  assign o_remainder = remainder_r;
  assign o_status    = status_r;

endmodule
